// File: rtl/mux_sel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_ctrl_pkg
//  Description : Shared mode encodings, parameter defaults and counter sizing
//                for the mux select controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_sel_ctrl_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd500000;
    localparam int unsigned AUTO_PERIOD_DEF     = 32'd50000000;

    // Keeps counters at least one bit wide for the smallest legal terminal count.
    function automatic int ctr_width(input int unsigned n);
        return (n > 32'd2) ? $clog2(n) : 1;
    endfunction

endpackage : mux_sel_ctrl_pkg
`default_nettype wire

// File: rtl/debounce.sv
`default_nettype none
// ============================================================================
//  Module      : debounce
//  Description : Two-flop synchronizer plus stability counter for an
//                active-low pushbutton; emits debounced level and press strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce
    import mux_sel_ctrl_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_n_i,
    output logic level_o,
    output logic rise_o
);

    localparam int              CW       = ctr_width(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 32'd1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          rise_q;
    logic          rise_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          w_pressed;

    assign w_pressed = ~sync2_q;

    // Counter only advances while the synced input disagrees with the accepted
    // level; any agreement, or an accepted flip, restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        if (w_pressed != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = w_pressed;
                rise_d   = w_pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;

endmodule : debounce
`default_nettype wire

// File: rtl/mux_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_ctrl
//  Description : 2:1 mux select generator: toggles on debounced button presses
//                or alternates at a fixed period in auto mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_ctrl
    import mux_sel_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned AUTO_PERIOD     = AUTO_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    input  logic auto_en,
    output logic sel,
    output logic sel_changed,
    output logic btn_level
);

    localparam int            PW          = ctr_width(AUTO_PERIOD);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(AUTO_PERIOD - 32'd1);

    logic          w_press;
    logic          w_level;
    logic          auto_s1_q;
    logic          auto_s2_q;
    mode_e         state_q;
    mode_e         state_d;
    logic [PW-1:0] period_q;
    logic [PW-1:0] period_d;
    logic          sel_q;
    logic          sel_d;
    logic          sel_chg_q;
    logic          w_toggle;

    debounce #(
        .STABLE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_n_i (btn_n),
        .level_o (w_level),
        .rise_o  (w_press)
    );

    // A press coinciding with period expiry yields a single toggle; both paths
    // restart the period from zero.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        w_toggle = 1'b0;
        case (state_q)
            MANUAL: begin
                period_d = '0;
                w_toggle = w_press;
                if (auto_s2_q) begin
                    state_d = AUTO;
                end
            end
            AUTO: begin
                if (w_press || (period_q == PERIOD_LAST)) begin
                    w_toggle = 1'b1;
                    period_d = '0;
                end else begin
                    period_d = period_q + 1'b1;
                end
                if (!auto_s2_q) begin
                    state_d = MANUAL;
                end
            end
            default: begin
                state_d  = MANUAL;
                period_d = '0;
            end
        endcase
        sel_d = sel_q ^ w_toggle;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_s1_q <= 1'b0;
            auto_s2_q <= 1'b0;
            state_q   <= MANUAL;
            period_q  <= '0;
            sel_q     <= 1'b1;
            sel_chg_q <= 1'b0;
        end else begin
            auto_s1_q <= auto_en;
            auto_s2_q <= auto_s1_q;
            state_q   <= state_d;
            period_q  <= period_d;
            sel_q     <= sel_d;
            sel_chg_q <= w_toggle;
        end
    end

    assign sel         = sel_q;
    assign sel_changed = sel_chg_q;
    assign btn_level   = w_level;

endmodule : mux_sel_ctrl
`default_nettype wire

// File: tb/tb_mux_sel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_sel_ctrl
//  Description : Self-checking bench for mux_sel_ctrl against a timeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_ctrl;

    localparam int D = 4;
    localparam int P = 10;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic btn_n   = 1'b1;
    logic auto_en = 1'b0;
    logic sel;
    logic sel_changed;
    logic btn_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_sel_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .AUTO_PERIOD     (P)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_n       (btn_n),
        .auto_en     (auto_en),
        .sel         (sel),
        .sel_changed (sel_changed),
        .btn_level   (btn_level)
    );

    // Reference model: edge counter t, raw-input delay queues for the
    // synchronizers, run start of disagreeing samples, and the time anchor of
    // the current auto period.
    bit m_sel      = 1'b1;
    bit m_chg      = 1'b0;
    bit m_level    = 1'b0;
    bit m_auto     = 1'b0;
    bit bq[$]      = '{1'b1, 1'b1};
    bit aq[$]      = '{1'b0, 1'b0};
    int t          = 0;
    int diff_start = -1;
    int press_at   = -10;
    int anchor     = 0;

    always @(posedge clk or negedge reset_n) begin : model
        bit s_press;
        bit s_auto;
        bit press;
        bit tog;
        if (!reset_n) begin
            m_sel = 1'b1; m_chg = 1'b0; m_level = 1'b0; m_auto = 1'b0;
            bq = '{1'b1, 1'b1}; aq = '{1'b0, 1'b0};
            t = 0; diff_start = -1; press_at = -10; anchor = 0;
        end else begin
            s_press = !bq[0];
            s_auto  = aq[0];
            void'(bq.pop_front()); bq.push_back(btn_n);
            void'(aq.pop_front()); aq.push_back(auto_en);
            t++;
            press = (press_at == t - 1);
            tog   = 1'b0;
            if (m_auto) begin
                if (press || (t - anchor == P)) begin
                    tog    = 1'b1;
                    anchor = t;
                end
            end else begin
                tog    = press;
                anchor = t;
            end
            m_auto = s_auto;
            if (s_press != m_level) begin
                if (diff_start < 0) diff_start = t;
                if (t - diff_start == D - 1) begin
                    m_level    = s_press;
                    diff_start = -1;
                    if (s_press) press_at = t;
                end
            end else begin
                diff_start = -1;
            end
            m_sel = m_sel ^ tog;
            m_chg = tog;
        end
    end

    task automatic check_val(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_val("sel", sel, m_sel);
        check_val("sel_changed", sel_changed, m_chg);
        check_val("btn_level", btn_level, m_level);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin : stim
        int pulses;
        int last_pulse;
        int hold;
        bit found;

        // Reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            step();
            check_val("rst_sel", sel, 1'b1);
            check_val("rst_chg", sel_changed, 1'b0);
            check_val("rst_lvl", btn_level, 1'b0);
            btn_n   = 1'($urandom_range(0, 1));
            auto_en = 1'($urandom_range(0, 1));
        end
        btn_n = 1'b1; auto_en = 1'b0;
        step();
        reset_n = 1'b1;
        run(4);

        // Clean press held 20 cycles, then release
        btn_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 5) check_val("clean_lvl_pre", btn_level, 1'b0);
            if (k == 6) check_val("clean_lvl", btn_level, 1'b1);
            if (k == 6) check_val("clean_sel_pre", sel, 1'b1);
            if (k == 7) check_val("clean_sel", sel, 1'b0);
            if (k == 7) check_val("clean_chg", sel_changed, 1'b1);
            if (k == 8) check_val("clean_chg_end", sel_changed, 1'b0);
        end
        btn_n = 1'b1;
        run(12);
        check_val("release_sel", sel, 1'b0);

        // Bounce shorter than the debounce window, then a valid press
        btn_n = 1'b0; run(3);
        btn_n = 1'b1; run(1);
        btn_n = 1'b0; run(2);
        btn_n = 1'b1; run(6);
        check_val("bounce_sel", sel, 1'b0);
        check_val("bounce_lvl", btn_level, 1'b0);
        btn_n = 1'b0; run(6);
        btn_n = 1'b1; run(10);
        check_val("bounce_press_sel", sel, 1'b1);

        // Auto alternation and freeze on exit
        auto_en    = 1'b1;
        pulses     = 0;
        last_pulse = -1;
        for (int k = 1; k <= 45; k++) begin
            step();
            if (sel_changed) begin
                if (last_pulse >= 0) check_val("auto_interval", 1'(k - last_pulse == P), 1'b1);
                last_pulse = k;
                pulses++;
            end
        end
        check_val("auto_pulses", 1'(pulses >= 4), 1'b1);
        auto_en = 1'b0;
        run(15);

        // Collision of press strobe with period wrap
        auto_en = 1'b1;
        found   = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (sel_changed) found = 1'b1;
        end
        check_val("coll_timeout", found, 1'b1);
        pulses = 0;
        for (int s = 1; s <= 20; s++) begin
            step();
            if (s == 3)  btn_n = 1'b0;
            if (s == 11) btn_n = 1'b1;
            if (s < 20 && sel_changed) pulses++;
            if (s == 10) check_val("coll_chg", sel_changed, 1'b1);
            if (s == 20) check_val("coll_next", sel_changed, 1'b1);
        end
        check_val("coll_single", 1'(pulses == 1), 1'b1);
        auto_en = 1'b0;
        run(10);

        // Reset in the middle of a debounce
        btn_n = 1'b0;
        run(2);
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check_val("midrst_sel", sel, 1'b1);
            check_val("midrst_lvl", btn_level, 1'b0);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 6) check_val("midrst_hold", sel, 1'b1);
            if (k == 7) check_val("midrst_toggle", sel, 1'b0);
        end
        btn_n = 1'b1;
        run(8);

        // Randomized traffic with occasional resets
        hold = 0;
        for (int k = 0; k < 1500; k++) begin
            step();
            if (hold == 0) begin
                btn_n = 1'($urandom_range(0, 1));
                hold  = $urandom_range(1, 7);
            end
            hold--;
            if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
            reset_n = ($urandom_range(0, 399) != 0);
        end
        reset_n = 1'b1;
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_sel_ctrl
`default_nettype wire
